snowflake_mem_arbiter: RTL and testbench
========================================

# snowflake_mem_arbiter

Arbitrates the single-port 4KB main memory of the snowflake platform between the core instruction port and the core data port. Data accesses have priority by default; a bounded starvation counter forces an instruction grant after a programmable number of consecutive contended data grants. The block sits between the core/system-bus decode and the main memory macro, and issues at most one memory access per cycle with one-cycle read latency.

## Interface
- STARVE_LIMIT, default 4: consecutive contended data grants before one forced instruction grant; 0 disables the boost (pure data priority); range 0-15.
- clk  in  1  clock; all state on rising edge.
- rstz  in  1  reset, asynchronous, active-low.
- instr_addr  in  32  instruction word address (byte address, bits [1:0] ignored by memory).
- instr_req  in  1  instruction request, level; held with stable addr until instr_ack.
- instr_ack  out  1  instruction grant complete; instr_data valid this cycle.
- instr_data  out  32  instruction read data.
- data_addr  in  32  data address (already decoded as main-memory region).
- data_wr_data  in  32  write data.
- data_mask  in  4  byte write mask.
- data_wr_en  in  1  1 = write, 0 = read.
- data_req  in  1  data request, level; held with stable addr/data until data_ack.
- data_ack  out  1  data access complete; data_rd_data valid this cycle if read.
- data_rd_data  out  32  data read data.
- mem_addr  out  32  memory address.
- mem_rd_data  in  32  memory read data, valid the cycle after mem_en.
- mem_wr_data  out  32  memory write data.
- mem_en  out  1  memory access strobe.
- mem_wr_en  out  1  memory write strobe.
- mem_mask  out  4  memory byte mask.
- boost  out  1  pulse: this cycle's grant is a forced instruction grant.

## Operation
- Issue cycle: grant is combinational from req inputs, starvation state and ack state.
- A requester is eligible iff req=1 and its ack is not asserted this cycle with req not re-asserted... concretely: req high in the ack cycle is treated as a new request (address already updated by requester) and is eligible.
- Only data eligible -> grant data. Only instr eligible -> grant instr. Neither -> mem_en=0, no grant.
- Both eligible (contended): if STARVE_LIMIT!=0 and starve_cnt==STARVE_LIMIT -> grant instr, boost=1; else grant data.
- starve_cnt (4 bits): on contended data grant, increment (saturate at STARVE_LIMIT); on any instr grant, clear; uncontended data grant or idle, hold.
- Grant data: mem_addr=data_addr, mem_wr_en=data_wr_en, mem_wr_data=data_wr_data, mem_mask=data_mask. Grant instr: mem_addr=instr_addr, mem_wr_en=0, mem_mask=data_mask (don't care).
- Ack registers: instr_ack_q<=instr granted, data_ack_q<=data granted; instr_ack/data_ack driven from these.
- instr_data and data_rd_data both driven from mem_rd_data unconditionally; valid only when respective ack=1. Writes also ack one cycle after issue.
- Never both acks in one cycle.

## Timing
- Reset (rstz low, async): instr_ack=0, data_ack=0, starve_cnt=0, boost=0, mem_en=0, mem_wr_en=0 (strobes gated by rstz combinationally); mem_addr/wr_data/mask follow inputs.
- Latency: issue in cycle N -> ack and read data in N+1. Throughput: one access per cycle, back-to-back allowed.
- Uncontended instr stream: ack every cycle after first.
- Reset asserted mid-access: outstanding ack is dropped; requester must re-issue after reset release. First issue possible in the first cycle rstz=1.
- STARVE_LIMIT=1: contended cycles alternate data, instr.
- Requests dropped before ack: arbiter drops grant eligibility immediately; an ack already registered still fires.

## Test plan
- Reset: hold rstz=0 with both req=1 -> mem_en=0, acks 0; release -> data granted first cycle, data_ack next cycle.
- Instr only: instr_req=1 at addrs 0x000,0x004,0x008 back-to-back, mem returns 0x11,0x22,0x33 -> instr_ack each of next 3 cycles with matching instr_data.
- Data write: data_req=1, wr_en=1, addr 0x100, data 0xDEADBEEF, mask 0xF -> mem_en=mem_wr_en=1 same cycle, data_ack next cycle, instr_ack=0.
- Starvation, STARVE_LIMIT=4: both req held high continuously -> data granted 4 cycles, 5th cycle instr granted with boost=1, then 4 data again; pattern repeats.
- STARVE_LIMIT=0: both req high 20 cycles -> data every cycle, instr never, boost never.
- Async reset mid-stream: assert rstz=0 between clock edges after issue -> acks clear immediately, starve_cnt=0, no ack on next edge.

Source files
------------

// File: rtl/snowflake_mem_arbiter.sv
// Single-port main memory arbiter: data port has priority over the instruction
// port, with a bounded starvation counter that forces an occasional instruction grant.
module snowflake_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rstz,
    input  logic [31:0] instr_addr,
    input  logic        instr_req,
    output logic        instr_ack,
    output logic [31:0] instr_data,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wr_data,
    input  logic [3:0]  data_mask,
    input  logic        data_wr_en,
    input  logic        data_req,
    output logic        data_ack,
    output logic [31:0] data_rd_data,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rd_data,
    output logic [31:0] mem_wr_data,
    output logic        mem_en,
    output logic        mem_wr_en,
    output logic [3:0]  mem_mask,
    output logic        boost
);

    localparam logic [3:0] LIMIT = STARVE_LIMIT[3:0];

    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic       instr_ack_q, instr_ack_d;
    logic       data_ack_q, data_ack_d;
    logic       contended;
    logic       force_instr;
    logic       grant_instr;
    logic       grant_data;

    // A request held high through its ack cycle already carries the next address,
    // so eligibility is simply the request level.
    always_comb begin
        contended    = instr_req & data_req;
        force_instr  = contended && (LIMIT != 4'd0) && (starve_cnt_q == LIMIT);
        grant_instr  = instr_req & (~data_req | force_instr);
        grant_data   = data_req & ~force_instr;

        starve_cnt_d = starve_cnt_q;
        if (grant_instr) begin
            starve_cnt_d = 4'd0;
        end else if (grant_data && contended && (starve_cnt_q != LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end

        instr_ack_d  = grant_instr;
        data_ack_d   = grant_data;
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            starve_cnt_q <= 4'd0;
            instr_ack_q  <= 1'b0;
            data_ack_q   <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            instr_ack_q  <= instr_ack_d;
            data_ack_q   <= data_ack_d;
        end
    end

    // Strobes are gated by rstz so nothing reaches the memory while reset is held.
    always_comb begin
        mem_en       = rstz & (grant_instr | grant_data);
        mem_wr_en    = rstz & grant_data & data_wr_en;
        boost        = rstz & force_instr;
        mem_addr     = grant_instr ? instr_addr : data_addr;
        mem_wr_data  = data_wr_data;
        mem_mask     = data_mask;
        instr_ack    = instr_ack_q;
        data_ack     = data_ack_q;
        instr_data   = mem_rd_data;
        data_rd_data = mem_rd_data;
    end

endmodule

// File: tb/tb_snowflake_mem_arbiter.sv
// Directed bench for snowflake_mem_arbiter: one instance with the default
// starvation limit and one with the boost disabled, sharing stimulus and memory.
module tb_snowflake_mem_arbiter;

    logic        clk = 1'b0;
    logic        rstz;
    logic [31:0] instr_addr;
    logic        instr_req;
    logic [31:0] data_addr;
    logic [31:0] data_wr_data;
    logic [3:0]  data_mask;
    logic        data_wr_en;
    logic        data_req;
    logic [31:0] mem_rd_data;

    logic        instr_ack, data_ack, mem_en, mem_wr_en, boost;
    logic [31:0] instr_data, data_rd_data, mem_addr, mem_wr_data;
    logic [3:0]  mem_mask;

    logic        instr_ack0, data_ack0, mem_en0, mem_wr_en0, boost0;
    logic [31:0] instr_data0, data_rd_data0, mem_addr0, mem_wr_data0;
    logic [3:0]  mem_mask0;

    logic [31:0] mem [0:1023];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    snowflake_mem_arbiter #(.STARVE_LIMIT(4)) u_dut (
        .clk(clk), .rstz(rstz),
        .instr_addr(instr_addr), .instr_req(instr_req),
        .instr_ack(instr_ack), .instr_data(instr_data),
        .data_addr(data_addr), .data_wr_data(data_wr_data), .data_mask(data_mask),
        .data_wr_en(data_wr_en), .data_req(data_req),
        .data_ack(data_ack), .data_rd_data(data_rd_data),
        .mem_addr(mem_addr), .mem_rd_data(mem_rd_data), .mem_wr_data(mem_wr_data),
        .mem_en(mem_en), .mem_wr_en(mem_wr_en), .mem_mask(mem_mask), .boost(boost)
    );

    snowflake_mem_arbiter #(.STARVE_LIMIT(0)) u_dut0 (
        .clk(clk), .rstz(rstz),
        .instr_addr(instr_addr), .instr_req(instr_req),
        .instr_ack(instr_ack0), .instr_data(instr_data0),
        .data_addr(data_addr), .data_wr_data(data_wr_data), .data_mask(data_mask),
        .data_wr_en(data_wr_en), .data_req(data_req),
        .data_ack(data_ack0), .data_rd_data(data_rd_data0),
        .mem_addr(mem_addr0), .mem_rd_data(mem_rd_data), .mem_wr_data(mem_wr_data0),
        .mem_en(mem_en0), .mem_wr_en(mem_wr_en0), .mem_mask(mem_mask0), .boost(boost0)
    );

    // Synchronous-read memory with byte-masked writes, driven by the main instance.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_wr_en) begin
                for (int b = 0; b < 4; b++)
                    if (mem_mask[b]) mem[mem_addr[11:2]][8*b +: 8] <= mem_wr_data[8*b +: 8];
            end
            mem_rd_data <= mem[mem_addr[11:2]];
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        instr_req    = 1'b0;
        data_req     = 1'b0;
        data_wr_en   = 1'b0;
        instr_addr   = 32'h0;
        data_addr    = 32'h0;
        data_wr_data = 32'h0;
        data_mask    = 4'h0;
    endtask

    task automatic do_reset();
        rstz = 1'b0;
        tick();
        tick();
        rstz = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[0] = 32'h11;
        mem[1] = 32'h22;
        mem[2] = 32'h33;
        mem_rd_data = 32'h0;
        idle_inputs();

        // Reset held with both requesters active
        rstz       = 1'b0;
        instr_req  = 1'b1;
        data_req   = 1'b1;
        instr_addr = 32'h0;
        data_addr  = 32'h8;
        tick();
        tick();
        check("rst_mem_en", {31'b0, mem_en}, 32'd0);
        check("rst_mem_wr_en", {31'b0, mem_wr_en}, 32'd0);
        check("rst_instr_ack", {31'b0, instr_ack}, 32'd0);
        check("rst_data_ack", {31'b0, data_ack}, 32'd0);
        check("rst_boost", {31'b0, boost}, 32'd0);
        rstz = 1'b1;
        #1;
        check("rel_mem_en", {31'b0, mem_en}, 32'd1);
        check("rel_mem_addr", mem_addr, 32'h8);
        tick();
        check("rel_data_ack", {31'b0, data_ack}, 32'd1);
        check("rel_instr_ack", {31'b0, instr_ack}, 32'd0);
        check("rel_rd_data", data_rd_data, 32'h33);
        idle_inputs();
        tick();
        do_reset();

        // Uncontended instruction stream
        instr_req  = 1'b1;
        instr_addr = 32'h000;
        #1;
        check("if_mem_en", {31'b0, mem_en}, 32'd1);
        check("if_mem_wr_en", {31'b0, mem_wr_en}, 32'd0);
        check("if_mem_addr", mem_addr, 32'h000);
        tick();
        check("if0_ack", {31'b0, instr_ack}, 32'd1);
        check("if0_data", instr_data, 32'h11);
        instr_addr = 32'h004;
        tick();
        check("if1_ack", {31'b0, instr_ack}, 32'd1);
        check("if1_data", instr_data, 32'h22);
        instr_addr = 32'h008;
        tick();
        check("if2_ack", {31'b0, instr_ack}, 32'd1);
        check("if2_data", instr_data, 32'h33);
        check("if2_data_ack", {31'b0, data_ack}, 32'd0);
        instr_req = 1'b0;
        tick();
        check("if_end_ack", {31'b0, instr_ack}, 32'd0);

        // Full-word data write, then a partial-mask write, each read back
        data_req     = 1'b1;
        data_wr_en   = 1'b1;
        data_addr    = 32'h100;
        data_wr_data = 32'hDEADBEEF;
        data_mask    = 4'hF;
        #1;
        check("wr_mem_en", {31'b0, mem_en}, 32'd1);
        check("wr_mem_wr_en", {31'b0, mem_wr_en}, 32'd1);
        check("wr_mem_addr", mem_addr, 32'h100);
        check("wr_mem_wr_data", mem_wr_data, 32'hDEADBEEF);
        check("wr_mem_mask", {28'b0, mem_mask}, 32'hF);
        tick();
        check("wr_data_ack", {31'b0, data_ack}, 32'd1);
        check("wr_instr_ack", {31'b0, instr_ack}, 32'd0);
        data_wr_data = 32'h12345678;
        data_mask    = 4'h3;
        tick();
        data_wr_en = 1'b0;
        tick();
        check("rd_data_ack", {31'b0, data_ack}, 32'd1);
        check("rd_masked_word", data_rd_data, 32'hDEAD5678);
        idle_inputs();
        tick();
        do_reset();

        // Contention: limit 4 gives DDDDI repeating; limit 0 never grants instr
        instr_req  = 1'b1;
        instr_addr = 32'h004;
        data_req   = 1'b1;
        data_addr  = 32'h100;
        for (int k = 0; k < 15; k++) begin
            logic exp_i;
            exp_i = ((k % 5) == 4);
            #1;
            check($sformatf("st%0d_boost", k), {31'b0, boost}, {31'b0, exp_i});
            check($sformatf("st%0d_addr", k), mem_addr, exp_i ? 32'h004 : 32'h100);
            check($sformatf("st%0d_boost0", k), {31'b0, boost0}, 32'd0);
            check($sformatf("st%0d_addr0", k), mem_addr0, 32'h100);
            tick();
            check($sformatf("st%0d_iack", k), {31'b0, instr_ack}, {31'b0, exp_i});
            check($sformatf("st%0d_dack", k), {31'b0, data_ack}, {31'b0, ~exp_i});
            check($sformatf("st%0d_iack0", k), {31'b0, instr_ack0}, 32'd0);
            check($sformatf("st%0d_dack0", k), {31'b0, data_ack0}, 32'd1);
        end
        for (int k = 15; k < 20; k++) begin
            tick();
            check($sformatf("st%0d_iack0", k), {31'b0, instr_ack0}, 32'd0);
        end
        idle_inputs();
        tick();
        do_reset();

        // Asynchronous reset mid-stream clears acks and the starvation count
        instr_req  = 1'b1;
        instr_addr = 32'h004;
        data_req   = 1'b1;
        data_addr  = 32'h100;
        tick();
        tick();
        tick();
        check("ar_pre_dack", {31'b0, data_ack}, 32'd1);
        #2;
        rstz = 1'b0;
        #1;
        check("ar_dack", {31'b0, data_ack}, 32'd0);
        check("ar_iack", {31'b0, instr_ack}, 32'd0);
        check("ar_mem_en", {31'b0, mem_en}, 32'd0);
        tick();
        check("ar_edge_dack", {31'b0, data_ack}, 32'd0);
        check("ar_edge_iack", {31'b0, instr_ack}, 32'd0);
        rstz = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("ar%0d_boost", k), {31'b0, boost}, (k == 4) ? 32'd1 : 32'd0);
            tick();
        end
        idle_inputs();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
